// File: rtl/pipeline_pkg.sv
// Shared encodings and address map for the RV32I memory / write-back stage.
// Decode works on the low 16 address bits; I/O registers decode by word.
package pipeline_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
    localparam logic [15:0] IO_LEDR   = 16'h7000;
    localparam logic [15:0] IO_LEDG   = 16'h7004;
    localparam logic [15:0] IO_HEX_LO = 16'h7008;
    localparam logic [15:0] IO_HEX_HI = 16'h700C;
    localparam logic [15:0] IO_SW     = 16'h7800;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_LEDR,
        RGN_LEDG,
        RGN_HEX_LO,
        RGN_HEX_HI,
        RGN_SW
    } region_e;

    function automatic region_e decode_region(input logic [15:0] addr);
        logic [15:0] ram_off;
        ram_off = addr - RAM_BASE;
        if (ram_off <= (RAM_LIMIT - RAM_BASE)) return RGN_RAM;
        else if (addr[15:2] == IO_LEDR[15:2])   return RGN_LEDR;
        else if (addr[15:2] == IO_LEDG[15:2])   return RGN_LEDG;
        else if (addr[15:2] == IO_HEX_LO[15:2]) return RGN_HEX_LO;
        else if (addr[15:2] == IO_HEX_HI[15:2]) return RGN_HEX_HI;
        else if (addr[15:2] == IO_SW[15:2])     return RGN_SW;
        else                                    return RGN_NONE;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        for (int k = 0; k < 4; k++)
            result[8*k +: 8] = lanes[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        return result;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Synchronous-read data RAM with per-byte write enables; the read register
// doubles as the W-stage copy of the loaded word.
module data_mem #(
    parameter  int WORDS = 2048,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_index,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    // NOTE: no reset on the array or its read register so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 4; k++)
                if (i_be[k]) r_mem[i_index][8*k +: 8] <= i_wdata[8*k +: 8];
        end
        r_rdata <= r_mem[i_index];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_writeback_stage.sv
// RV32I memory stage fused with the MEM/WB register: stores, loads, memory-mapped
// I/O, switch synchronizer, load extraction and the write-back mux.
module mem_writeback_stage
    import pipeline_pkg::*;
#(
    parameter int DMEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        mem_wrenM,
    input  logic        rd_wrenM,
    input  logic [1:0]  wb_selM,
    input  logic [2:0]  ld_selM,
    input  logic [3:0]  byte_enM,
    input  logic [4:0]  rd_addrM,
    input  logic [12:0] pc4M,
    input  logic [31:0] alu_dataM,
    input  logic [31:0] forward2outM,
    input  logic [31:0] io_sw,
    output logic        rd_wrenW,
    output logic [4:0]  rd_addrW,
    output logic [31:0] wb_dataW,
    output logic [31:0] io_ledr,
    output logic [31:0] io_ledg,
    output logic [31:0] io_hex_lo,
    output logic [31:0] io_hex_hi
);

    localparam int AW = $clog2(DMEM_WORDS);

    region_e     w_region;
    logic [31:0] w_store_data;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_io_rdata;

    logic [31:0] r_ledr, r_ledg, r_hex_lo, r_hex_hi;
    logic [31:0] r_sw_meta, r_sw_sync;

    logic [2:0]  r_ld_sel;
    logic [1:0]  r_offset;
    logic        r_is_ram;
    logic [1:0]  r_wb_sel;
    logic [31:0] r_alu_data;
    logic [12:0] r_pc4;
    logic [4:0]  r_rd_addr;
    logic        r_rd_wren;
    logic [31:0] r_io_rdata;

    logic [31:0] w_load_word;
    logic [31:0] w_load_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;

    assign w_region     = decode_region(alu_dataM[15:0]);
    assign w_store_data = forward2outM << {alu_dataM[1:0], 3'b000};
    // Reset gates the RAM write so a store caught in M during reset is dropped.
    assign w_ram_we     = mem_wrenM && aclr && (w_region == RGN_RAM);

    data_mem #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk     (clk),
        .i_index (alu_dataM[AW+1:2]),
        .i_we    (w_ram_we),
        .i_be    (byte_enM),
        .i_wdata (w_store_data),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_ledr   <= '0;
            r_ledg   <= '0;
            r_hex_lo <= '0;
            r_hex_hi <= '0;
        end else if (mem_wrenM) begin
            case (w_region)
                RGN_LEDR:   r_ledr   <= merge_lanes(r_ledr,   w_store_data, byte_enM);
                RGN_LEDG:   r_ledg   <= merge_lanes(r_ledg,   w_store_data, byte_enM);
                RGN_HEX_LO: r_hex_lo <= merge_lanes(r_hex_lo, w_store_data, byte_enM);
                RGN_HEX_HI: r_hex_hi <= merge_lanes(r_hex_hi, w_store_data, byte_enM);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= io_sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_io_rdata = '0;
        case (w_region)
            RGN_LEDR:   w_io_rdata = r_ledr;
            RGN_LEDG:   w_io_rdata = r_ledg;
            RGN_HEX_LO: w_io_rdata = r_hex_lo;
            RGN_HEX_HI: w_io_rdata = r_hex_hi;
            RGN_SW:     w_io_rdata = r_sw_sync;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_ld_sel   <= '0;
            r_offset   <= '0;
            r_is_ram   <= 1'b0;
            r_wb_sel   <= '0;
            r_alu_data <= '0;
            r_pc4      <= '0;
            r_rd_addr  <= '0;
            r_rd_wren  <= 1'b0;
            r_io_rdata <= '0;
        end else begin
            r_ld_sel   <= ld_selM;
            r_offset   <= alu_dataM[1:0];
            r_is_ram   <= (w_region == RGN_RAM);
            r_wb_sel   <= wb_selM;
            r_alu_data <= alu_dataM;
            r_pc4      <= pc4M;
            r_rd_addr  <= rd_addrM;
            r_rd_wren  <= rd_wrenM;
            r_io_rdata <= w_io_rdata;
        end
    end

    assign w_load_word    = r_is_ram ? w_ram_rdata : r_io_rdata;
    // Offset-3 halfwords naturally pick up zeros in bits 15:8 from the shift.
    assign w_load_shifted = w_load_word >> {r_offset, 3'b000};

    always_comb begin
        w_load_data = w_load_shifted;
        case (r_ld_sel)
            LD_LB:   w_load_data = {{24{w_load_shifted[7]}},  w_load_shifted[7:0]};
            LD_LH:   w_load_data = {{16{w_load_shifted[15]}}, w_load_shifted[15:0]};
            LD_LBU:  w_load_data = {24'b0, w_load_shifted[7:0]};
            LD_LHU:  w_load_data = {16'b0, w_load_shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_wb_data = r_alu_data;
        case (r_wb_sel)
            WB_LOAD: w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = {19'b0, r_pc4};
            default: ;
        endcase
    end

    assign wb_dataW  = w_wb_data;
    assign rd_wrenW  = r_rd_wren;
    assign rd_addrW  = r_rd_addr;
    assign io_ledr   = r_ledr;
    assign io_ledg   = r_ledg;
    assign io_hex_lo = r_hex_lo;
    assign io_hex_hi = r_hex_hi;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage: a vector table of M-stage operations
// with hand-computed W results, plus sequences for sync timing and reset.
module tb_mem_writeback_stage;

    logic        clk = 1'b0;
    logic        aclr;
    logic        mem_wrenM, rd_wrenM;
    logic [1:0]  wb_selM;
    logic [2:0]  ld_selM;
    logic [3:0]  byte_enM;
    logic [4:0]  rd_addrM;
    logic [12:0] pc4M;
    logic [31:0] alu_dataM, forward2outM, io_sw;
    logic        rd_wrenW;
    logic [4:0]  rd_addrW;
    logic [31:0] wb_dataW, io_ledr, io_ledg, io_hex_lo, io_hex_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_writeback_stage #(.DMEM_WORDS(2048)) dut (
        .clk          (clk),
        .aclr         (aclr),
        .mem_wrenM    (mem_wrenM),
        .rd_wrenM     (rd_wrenM),
        .wb_selM      (wb_selM),
        .ld_selM      (ld_selM),
        .byte_enM     (byte_enM),
        .rd_addrM     (rd_addrM),
        .pc4M         (pc4M),
        .alu_dataM    (alu_dataM),
        .forward2outM (forward2outM),
        .io_sw        (io_sw),
        .rd_wrenW     (rd_wrenW),
        .rd_addrW     (rd_addrW),
        .wb_dataW     (wb_dataW),
        .io_ledr      (io_ledr),
        .io_ledg      (io_ledg),
        .io_hex_lo    (io_hex_lo),
        .io_hex_hi    (io_hex_hi)
    );

    typedef struct {
        logic        we;
        logic        rdw;
        logic [1:0]  wb;
        logic [2:0]  ld;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [12:0] pc4;
        logic [31:0] exp_wb;
        logic [31:0] exp_ledr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic rdw, input logic [1:0] wb,
                                input logic [2:0] ld, input logic [3:0] be, input logic [4:0] rd,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [12:0] pc4, input logic [31:0] exp_wb,
                                input logic [31:0] exp_ledr);
        vec_t v;
        v.we = we; v.rdw = rdw; v.wb = wb; v.ld = ld; v.be = be; v.rd = rd;
        v.addr = addr; v.data = data; v.pc4 = pc4; v.exp_wb = exp_wb; v.exp_ledr = exp_ledr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        mem_wrenM    = v.we;
        rd_wrenM     = v.rdw;
        wb_selM      = v.wb;
        ld_selM      = v.ld;
        byte_enM     = v.be;
        rd_addrM     = v.rd;
        alu_dataM    = v.addr;
        forward2outM = v.data;
        pc4M         = v.pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we rdw wb ld be rd addr data pc4 exp_wb exp_ledr
        vecs.push_back(mk(1, 0, 2'b00, 3'b010, 4'b1111, 0,  32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0000_0100, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 3,  32'h0000_0100, 0, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, 0, 2'b00, 3'b000, 4'b0100, 0,  32'h0000_0102, 32'h0000_00A5, 0, 32'h0000_0102, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b000, 4'b0000, 4,  32'h0000_0102, 0, 0, 32'hFFFF_FFA5, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b100, 4'b0000, 5,  32'h0000_0102, 0, 0, 32'h0000_00A5, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 6,  32'h0000_0100, 0, 0, 32'hDEA5_BEEF, 0));
        vecs.push_back(mk(1, 0, 2'b00, 3'b001, 4'b1100, 0,  32'h0000_0206, 32'h0000_8001, 0, 32'h0000_0206, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b001, 4'b0000, 7,  32'h0000_0206, 0, 0, 32'hFFFF_8001, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b101, 4'b0000, 8,  32'h0000_0206, 0, 0, 32'h0000_8001, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b001, 4'b0000, 9,  32'h0000_0103, 0, 0, 32'h0000_00DE, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3'b000, 4'b0000, 10, 32'h0000_0101, 0, 0, 32'hFFFF_FFBE, 0));
        vecs.push_back(mk(1, 0, 2'b00, 3'b010, 4'b1111, 0,  32'h0000_7000, 32'h1234_5678, 0, 32'h0000_7000, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 11, 32'h0000_7000, 0, 0, 32'h1234_5678, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 12, 32'h0000_7004, 0, 0, 32'h0000_0000, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 13, 32'h0000_7FF0, 0, 0, 32'h0000_0000, 32'h1234_5678));
        vecs.push_back(mk(1, 0, 2'b00, 3'b010, 4'b1111, 0,  32'h0000_7800, 32'hCAFE_F00D, 0, 32'h0000_7800, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 14, 32'h0000_7800, 0, 0, 32'h0000_0000, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 15, 32'h0001_7000, 0, 0, 32'h1234_5678, 32'h1234_5678));
        vecs.push_back(mk(1, 0, 2'b00, 3'b000, 4'b1000, 0,  32'h0000_700B, 32'h0000_0077, 0, 32'h0000_700B, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 16, 32'h0000_7008, 0, 0, 32'h7700_0000, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b11, 3'b010, 4'b0000, 31, 32'hABCD_1234, 0, 0, 32'hABCD_1234, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b10, 3'b010, 4'b0000, 2,  32'h0000_0040, 0, 13'h1FFC, 32'h0000_1FFC, 32'h1234_5678));
        vecs.push_back(mk(1, 0, 2'b00, 3'b010, 4'b0000, 0,  32'h0000_7000, 32'hFFFF_FFFF, 0, 32'h0000_7000, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'b01, 3'b010, 4'b0000, 17, 32'h0000_7000, 0, 0, 32'h1234_5678, 32'h1234_5678));

        aclr  = 1'b1;
        io_sw = '0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 aclr = 1'b0;
        #1;
        check("reset_rd_wren", {31'b0, rd_wrenW}, 32'h0);
        check("reset_rd_addr", {27'b0, rd_addrW}, 32'h0);
        check("reset_wb_data", wb_dataW, 32'h0);
        check("reset_ledr", io_ledr, 32'h0);
        check("reset_ledg", io_ledg, 32'h0);
        check("reset_hex", io_hex_lo | io_hex_hi, 32'h0);
        step();
        step();
        aclr = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            step();
            check($sformatf("vec%0d_wb", i), wb_dataW, vecs[i].exp_wb);
            check($sformatf("vec%0d_rdw", i), {31'b0, rd_wrenW}, {31'b0, vecs[i].rdw});
            check($sformatf("vec%0d_rd", i), {27'b0, rd_addrW}, {27'b0, vecs[i].rd});
            check($sformatf("vec%0d_ledr", i), io_ledr, vecs[i].exp_ledr);
        end
        check("post_ledg", io_ledg, 32'h0);
        check("post_hex_lo", io_hex_lo, 32'h7700_0000);
        check("post_hex_hi", io_hex_hi, 32'h0);

        // Switch synchronizer: two edges before a load can see the new value.
        io_sw = 32'h0000_FFFF;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        apply(mk(0, 1, 2'b01, 3'b010, 4'b0000, 1, 32'h0000_7800, 0, 0, 0, 0));
        step();
        check("sw_one_edge", wb_dataW, 32'h0);
        step();
        check("sw_two_edges", wb_dataW, 32'h0000_FFFF);

        // Reset lands while a store to LEDG sits in M.
        apply(mk(1, 1, 2'b00, 3'b010, 4'b1111, 5, 32'h0000_7004, 32'h0000_0055, 0, 0, 0));
        #2 aclr = 1'b0;
        #1;
        check("rst_async_rd_wren", {31'b0, rd_wrenW}, 32'h0);
        check("rst_async_wb", wb_dataW, 32'h0);
        step();
        check("rst_ledg", io_ledg, 32'h0);
        check("rst_ledr_cleared", io_ledr, 32'h0);
        check("rst_hex_lo_cleared", io_hex_lo, 32'h0);
        apply(mk(0, 1, 2'b10, 3'b000, 4'b0000, 1, 32'h0000_0000, 0, 13'h0124, 0, 0));
        aclr = 1'b1;
        step();
        check("jal_wb", wb_dataW, 32'h0000_0124);
        check("jal_rdw", {31'b0, rd_wrenW}, 32'h1);
        check("jal_rd", {27'b0, rd_addrW}, 32'h1);
        check("jal_ledg", io_ledg, 32'h0);

        apply(mk(0, 1, 2'b01, 3'b010, 4'b0000, 9, 32'h0000_0100, 0, 0, 0, 0));
        step();
        check("ram_kept_over_reset", wb_dataW, 32'hDEA5_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
